gate_sched: RTL

GATE_SCHED -- requirements
Module: gate_sched

---
 rtl/gate_sched.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/gate_sched.sv
// gate_sched: timed measurement sequencer SYNC -> GDEL -> GATE -> LEN,
// repeated Nrep+1 times and closed by a one-cycle DONE pulse.
// Optional feature: define GATE_SCHED_ABORT_EN to add the abort/aborted pair.
module gate_sched #(
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       Tsync,
    input  logic [7:0]       Tgdel,
    input  logic [15:0]      Tgate,
    input  logic [15:0]      Tlen,
    input  logic [REP_W-1:0] Nrep,
`ifdef GATE_SCHED_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic             Sync,
    output logic             Gate,
    output logic             Done,
    output logic             busy,
    output logic [REP_W-1:0] rep_idx
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        GDEL,
        GATE,
        LEN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [15:0]      cnt;
    logic [15:0]      term;
    logic [7:0]       tsync_q;
    logic [7:0]       tgdel_q;
    logic [15:0]      tgate_q;
    logic [15:0]      tlen_q;
    logic [REP_W-1:0] nrep_q;
    logic             accept;
    logic             phase_end;
    logic             rep_adv;
    logic             abort_take;

    assign cmd_ready = (state == IDLE) && ena;
    assign accept    = cmd_ready && cmd_valid;

`ifdef GATE_SCHED_ABORT_EN
    // An abort only cancels a running sequence; IDLE ignores it and DONE wins.
    assign abort_take = abort && ena && (state != IDLE) && (state != DONE);
`else
    assign abort_take = 1'b0;
`endif

    // Terminal count of the active timed phase; 8-bit phases are zero-extended.
    always_comb begin
        // NOTE: default assignment first so no path leaves term unassigned (no latch).
        term = 16'd0;
        case (state)
            SYNC:    term = {8'd0, tsync_q};
            GDEL:    term = {8'd0, tgdel_q};
            GATE:    term = tgate_q;
            LEN:     term = tlen_q;
            default: term = 16'd0;
        endcase
    end

    assign phase_end = (cnt == term);

    // Next-state decision; everything freezes while ena is low.
    always_comb begin
        state_nxt = state;
        rep_adv   = 1'b0;
        if (ena) begin
            case (state)
                IDLE: if (cmd_valid) state_nxt = SYNC;
                SYNC: if (phase_end) state_nxt = GDEL;
                GDEL: if (phase_end) state_nxt = GATE;
                GATE: if (phase_end) state_nxt = LEN;
                LEN: begin
                    if (phase_end) begin
                        if (rep_idx == nrep_q) begin
                            state_nxt = DONE;
                        end else begin
                            state_nxt = SYNC;
                            rep_adv   = 1'b1;
                        end
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
            if (abort_take) begin
                state_nxt = IDLE;
                rep_adv   = 1'b0;
            end
        end
    end

    // State, counter, latched parameters and registered Moore outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state   <= IDLE;
            cnt     <= 16'd0;
            rep_idx <= '0;
            tsync_q <= 8'd0;
            tgdel_q <= 8'd0;
            tgate_q <= 16'd0;
            tlen_q  <= 16'd0;
            nrep_q  <= '0;
            Sync    <= 1'b0;
            Gate    <= 1'b0;
            Done    <= 1'b0;
            busy    <= 1'b0;
`ifdef GATE_SCHED_ABORT_EN
            aborted <= 1'b0;
`endif
        end else if (ena) begin
            state <= state_nxt;
            // The counter runs only while a timed phase continues; any phase
            // change clears it, so it stops at term and can never wrap.
            if ((state_nxt == state) && (state != IDLE)) begin
                cnt <= cnt + 16'd1;
            end else begin
                cnt <= 16'd0;
            end
            if (accept) begin
                tsync_q <= Tsync;
                tgdel_q <= Tgdel;
                tgate_q <= Tgate;
                tlen_q  <= Tlen;
                nrep_q  <= Nrep;
                rep_idx <= '0;
            end else if (rep_adv) begin
                rep_idx <= rep_idx + 1'b1;
            end
            Sync <= (state_nxt == SYNC);
            Gate <= (state_nxt == GATE);
            Done <= (state_nxt == DONE);
            busy <= (state_nxt != IDLE);
`ifdef GATE_SCHED_ABORT_EN
            aborted <= abort_take;
`endif
        end
    end

endmodule
